// File: rtl/input_command_decoder_pkg.sv
// ============================================================================
// input_command_decoder_pkg : shared encodings for the player input decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

package input_command_decoder_pkg;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;

    localparam logic AXIS_X = 1'b0;
    localparam logic AXIS_Y = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_REPEAT = 2'd2
    } step_state_t;

endpackage

`default_nettype wire

// File: rtl/input_command_decoder_player_input_channel.sv
// ============================================================================
// player_input_channel : one player's key resolution, step FSM, bomb cooldown
// Revision: 1.0
// ============================================================================
`default_nettype none

module player_input_channel
    import input_command_decoder_pkg::*;
#(
    parameter int CNT_W         = 26,
    parameter int FIRST_DELAY   = 25000000,
    parameter int REPEAT_CYCLES = 12500000,
    parameter int BOMB_COOLDOWN = 50000000,
    parameter int ALLOW_DIAG    = 1
) (
    input  logic clock,
    input  logic resetn,
    input  logic enable,
    input  logic key_up,
    input  logic key_down,
    input  logic key_left,
    input  logic key_right,
    input  logic key_bomb,
    output logic xdir,
    output logic ydir,
    output logic x_mov,
    output logic y_mov,
    output logic step,
    output logic bomb
);

    if (FIRST_DELAY < 1 || longint'(FIRST_DELAY) >= (longint'(1) << CNT_W) ||
        REPEAT_CYCLES < 1 || longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W) ||
        BOMB_COOLDOWN < 1 || longint'(BOMB_COOLDOWN) >= (longint'(1) << CNT_W)) begin : g_bad_params
        $error("player_input_channel: timing parameters must be in [1, 2^CNT_W)");
    end

    localparam logic [CNT_W-1:0] FIRST_LOAD  = CNT_W'(FIRST_DELAY - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(BOMB_COOLDOWN);
    localparam bit               DIAG        = (ALLOW_DIAG != 0);

    logic prev_up, prev_down, prev_left, prev_right, prev_bomb;
    logic last_x, last_y, last_axis;
    logic rise_up, rise_down, rise_left, rise_right, rise_bomb;
    logic last_x_nxt, last_y_nxt, last_axis_nxt;
    logic x_act, y_act, xdir_res, ydir_res, x_mov_res, y_mov_res;
    logic xdir_nxt, ydir_nxt, step_nxt, bomb_nxt;
    logic [3:0] mot, prev_mot;
    step_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cooldown, cooldown_nxt;

    assign rise_up    = key_up    & ~prev_up;
    assign rise_down  = key_down  & ~prev_down;
    assign rise_left  = key_left  & ~prev_left;
    assign rise_right = key_right & ~prev_right;
    assign rise_bomb  = key_bomb  & ~prev_bomb;

    // Simultaneous rises favour right/down, and x over y for axis selection.
    assign last_x_nxt    = rise_right ? DIR_RIGHT : (rise_left ? DIR_LEFT : last_x);
    assign last_y_nxt    = rise_down  ? DIR_DOWN  : (rise_up   ? DIR_UP   : last_y);
    assign last_axis_nxt = (rise_left | rise_right) ? AXIS_X :
                           ((rise_up | rise_down) ? AXIS_Y : last_axis);

    assign x_act = key_left | key_right;
    assign y_act = key_up   | key_down;

    assign xdir_res = (key_left & key_right) ? last_x_nxt :
                      (key_right ? DIR_RIGHT : (key_left ? DIR_LEFT : xdir));
    assign ydir_res = (key_up & key_down) ? last_y_nxt :
                      (key_down ? DIR_DOWN : (key_up ? DIR_UP : ydir));

    assign x_mov_res = x_act & (DIAG | ~y_act | (last_axis_nxt == AXIS_X));
    assign y_mov_res = y_act & (DIAG | ~x_act | (last_axis_nxt == AXIS_Y));

    assign xdir_nxt = enable ? xdir_res : xdir;
    assign ydir_nxt = enable ? ydir_res : ydir;
    // Direction bits only matter while that axis moves, so mask them in the motion word.
    assign mot = enable ? {x_mov_res, y_mov_res, x_mov_res & xdir_res, y_mov_res & ydir_res}
                        : 4'b0000;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_nxt  = 1'b0;
        if (mot == 4'b0000) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    step_nxt  = 1'b1;
                    cnt_nxt   = FIRST_LOAD;
                    state_nxt = ST_FIRST;
                end
                default: begin
                    if (mot != prev_mot) begin
                        step_nxt  = 1'b1;
                        cnt_nxt   = FIRST_LOAD;
                        state_nxt = ST_FIRST;
                    end else if (cnt == '0) begin
                        step_nxt  = 1'b1;
                        cnt_nxt   = REPEAT_LOAD;
                        state_nxt = ST_REPEAT;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bomb_nxt     = enable & rise_bomb & (cooldown == '0);
    assign cooldown_nxt = bomb_nxt ? COOL_LOAD :
                          ((cooldown != '0) ? cooldown - 1'b1 : cooldown);

    always_ff @(posedge clock) begin
        if (resetn) begin
            prev_up    <= 1'b0;
            prev_down  <= 1'b0;
            prev_left  <= 1'b0;
            prev_right <= 1'b0;
            prev_bomb  <= 1'b0;
            last_x     <= 1'b0;
            last_y     <= 1'b0;
            last_axis  <= 1'b0;
            xdir       <= 1'b0;
            ydir       <= 1'b0;
            x_mov      <= 1'b0;
            y_mov      <= 1'b0;
            step       <= 1'b0;
            bomb       <= 1'b0;
            state      <= ST_IDLE;
            cnt        <= '0;
            prev_mot   <= 4'b0000;
            cooldown   <= '0;
        end else begin
            prev_up    <= key_up;
            prev_down  <= key_down;
            prev_left  <= key_left;
            prev_right <= key_right;
            prev_bomb  <= key_bomb;
            last_x     <= last_x_nxt;
            last_y     <= last_y_nxt;
            last_axis  <= last_axis_nxt;
            xdir       <= xdir_nxt;
            ydir       <= ydir_nxt;
            x_mov      <= mot[3];
            y_mov      <= mot[2];
            step       <= step_nxt;
            bomb       <= bomb_nxt;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            prev_mot   <= mot;
            cooldown   <= cooldown_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/input_command_decoder.sv
// ============================================================================
// input_command_decoder : per-player movement/bomb decoding for NUM_PLAYERS
// Revision: 1.0
// ============================================================================
`default_nettype none

module input_command_decoder
    import input_command_decoder_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int CNT_W         = 26,
    parameter int FIRST_DELAY   = 25000000,
    parameter int REPEAT_CYCLES = 12500000,
    parameter int BOMB_COOLDOWN = 50000000,
    parameter int ALLOW_DIAG    = 1
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [NUM_PLAYERS-1:0] key_up,
    input  logic [NUM_PLAYERS-1:0] key_down,
    input  logic [NUM_PLAYERS-1:0] key_left,
    input  logic [NUM_PLAYERS-1:0] key_right,
    input  logic [NUM_PLAYERS-1:0] key_bomb,
    output logic [NUM_PLAYERS-1:0] p_xdir,
    output logic [NUM_PLAYERS-1:0] p_ydir,
    output logic [NUM_PLAYERS-1:0] p_x_mov,
    output logic [NUM_PLAYERS-1:0] p_y_mov,
    output logic [NUM_PLAYERS-1:0] p_step,
    output logic [NUM_PLAYERS-1:0] p_bomb
);

    for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
        player_input_channel #(
            .CNT_W         (CNT_W),
            .FIRST_DELAY   (FIRST_DELAY),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .BOMB_COOLDOWN (BOMB_COOLDOWN),
            .ALLOW_DIAG    (ALLOW_DIAG)
        ) u_channel (
            .clock     (clock),
            .resetn    (resetn),
            .enable    (enable),
            .key_up    (key_up[i]),
            .key_down  (key_down[i]),
            .key_left  (key_left[i]),
            .key_right (key_right[i]),
            .key_bomb  (key_bomb[i]),
            .xdir      (p_xdir[i]),
            .ydir      (p_ydir[i]),
            .x_mov     (p_x_mov[i]),
            .y_mov     (p_y_mov[i]),
            .step      (p_step[i]),
            .bomb      (p_bomb[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_input_command_decoder.sv
// ============================================================================
// tb_input_command_decoder : directed scoreboard bench, diagonal and single-axis
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_input_command_decoder;

    localparam int S_XDIR = 0, S_YDIR = 1, S_XMOV = 2, S_YMOV = 3, S_STEP = 4, S_BOMB = 5;
    localparam int D_DIAG = 0, D_SA = 1;

    logic clock = 1'b0;
    logic resetn, enable;
    logic [1:0] key_up, key_down, key_left, key_right, key_bomb;
    logic [1:0] a_xdir, a_ydir, a_xmov, a_ymov, a_step, a_bomb;
    logic [1:0] b_xdir, b_ydir, b_xmov, b_ymov, b_step, b_bomb;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        int         dut;
        int         sig;
        logic [1:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    input_command_decoder #(
        .NUM_PLAYERS(2), .CNT_W(26), .FIRST_DELAY(4), .REPEAT_CYCLES(2),
        .BOMB_COOLDOWN(3), .ALLOW_DIAG(1)
    ) dut (
        .clock(clock), .resetn(resetn), .enable(enable),
        .key_up(key_up), .key_down(key_down), .key_left(key_left),
        .key_right(key_right), .key_bomb(key_bomb),
        .p_xdir(a_xdir), .p_ydir(a_ydir), .p_x_mov(a_xmov), .p_y_mov(a_ymov),
        .p_step(a_step), .p_bomb(a_bomb)
    );

    input_command_decoder #(
        .NUM_PLAYERS(2), .CNT_W(26), .FIRST_DELAY(4), .REPEAT_CYCLES(2),
        .BOMB_COOLDOWN(3), .ALLOW_DIAG(0)
    ) dut_sa (
        .clock(clock), .resetn(resetn), .enable(enable),
        .key_up(key_up), .key_down(key_down), .key_left(key_left),
        .key_right(key_right), .key_bomb(key_bomb),
        .p_xdir(b_xdir), .p_ydir(b_ydir), .p_x_mov(b_xmov), .p_y_mov(b_ymov),
        .p_step(b_step), .p_bomb(b_bomb)
    );

    function automatic logic [1:0] get_out(int d, int s);
        logic [1:0] r;
        case (s)
            S_XDIR:  r = (d == D_DIAG) ? a_xdir : b_xdir;
            S_YDIR:  r = (d == D_DIAG) ? a_ydir : b_ydir;
            S_XMOV:  r = (d == D_DIAG) ? a_xmov : b_xmov;
            S_YMOV:  r = (d == D_DIAG) ? a_ymov : b_ymov;
            S_STEP:  r = (d == D_DIAG) ? a_step : b_step;
            default: r = (d == D_DIAG) ? a_bomb : b_bomb;
        endcase
        return r;
    endfunction

    task automatic expect_out(input string tag, input int d, input int s, input logic [1:0] v);
        exp_t e;
        e.tag = tag; e.dut = d; e.sig = s; e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_all_zero(input string tag, input int d);
        for (int s = 0; s < 6; s++) expect_out(tag, d, s, 2'b00);
    endtask

    task automatic check_now();
        while (sb.size() > 0) begin
            exp_t e;
            logic [1:0] obs;
            e   = sb.pop_front();
            obs = get_out(e.dut, e.sig);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s (dut %0d sig %0d): observed %b expected %b",
                       e.tag, e.dut, e.sig, obs, e.val);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        check_now();
    endtask

    initial begin
        logic [7:0] step_pat;
        logic [5:0] bomb_in;
        logic [5:0] bomb_exp;

        // Reset with every key held
        resetn = 1'b1; enable = 1'b1;
        key_up = 2'b11; key_down = 2'b11; key_left = 2'b11; key_right = 2'b11; key_bomb = 2'b11;
        for (int i = 0; i < 2; i++) begin
            expect_all_zero("reset_diag", D_DIAG);
            expect_all_zero("reset_sa", D_SA);
            cyc();
        end
        resetn = 1'b0;
        key_up = 2'b00; key_down = 2'b00; key_left = 2'b00; key_right = 2'b00; key_bomb = 2'b00;
        expect_all_zero("post_reset", D_DIAG);
        expect_all_zero("post_reset_sa", D_SA);
        check_now();
        expect_all_zero("idle", D_DIAG);
        cyc();

        // Step timing: initial step, first repeat after 4, then every 2
        key_right = 2'b01;
        expect_out("right_xmov", D_DIAG, S_XMOV, 2'b01);
        expect_out("right_xdir", D_DIAG, S_XDIR, 2'b01);
        expect_out("right_step0", D_DIAG, S_STEP, 2'b01);
        cyc();
        step_pat = 8'b1010_1000;
        for (int i = 0; i < 8; i++) begin
            expect_out("repeat_step", D_DIAG, S_STEP, {1'b0, step_pat[i]});
            expect_out("repeat_xmov", D_DIAG, S_XMOV, 2'b01);
            cyc();
        end

        // Opposing keys: last pressed wins
        key_left = 2'b01;
        expect_out("left_over_right_xdir", D_DIAG, S_XDIR, 2'b00);
        expect_out("left_over_right_step", D_DIAG, S_STEP, 2'b01);
        expect_out("left_over_right_xmov", D_DIAG, S_XMOV, 2'b01);
        cyc();
        for (int i = 0; i < 3; i++) begin
            expect_out("both_held_nostep", D_DIAG, S_STEP, 2'b00);
            expect_out("both_held_xdir", D_DIAG, S_XDIR, 2'b00);
            cyc();
        end
        key_left = 2'b00;
        expect_out("release_left_xdir", D_DIAG, S_XDIR, 2'b01);
        expect_out("release_left_step", D_DIAG, S_STEP, 2'b01);
        cyc();
        expect_out("release_left_hold", D_DIAG, S_STEP, 2'b00);
        cyc();
        key_right = 2'b00;
        expect_out("release_right_xmov", D_DIAG, S_XMOV, 2'b00);
        expect_out("release_right_step", D_DIAG, S_STEP, 2'b00);
        expect_out("release_right_xdir", D_DIAG, S_XDIR, 2'b01);
        cyc();
        for (int i = 0; i < 2; i++) begin
            expect_out("stopped_step", D_DIAG, S_STEP, 2'b00);
            cyc();
        end

        // Single-axis mode versus diagonal mode
        key_up = 2'b01;
        expect_out("up_ymov", D_DIAG, S_YMOV, 2'b01);
        expect_out("up_xmov", D_DIAG, S_XMOV, 2'b00);
        expect_out("up_step", D_DIAG, S_STEP, 2'b01);
        expect_out("sa_up_ymov", D_SA, S_YMOV, 2'b01);
        expect_out("sa_up_xmov", D_SA, S_XMOV, 2'b00);
        expect_out("sa_up_ydir", D_SA, S_YDIR, 2'b00);
        expect_out("sa_up_step", D_SA, S_STEP, 2'b01);
        cyc();
        expect_out("sa_up_hold", D_SA, S_STEP, 2'b00);
        cyc();
        key_left = 2'b01;
        expect_out("sa_left_ymov", D_SA, S_YMOV, 2'b00);
        expect_out("sa_left_xmov", D_SA, S_XMOV, 2'b01);
        expect_out("sa_left_xdir", D_SA, S_XDIR, 2'b00);
        expect_out("sa_left_step", D_SA, S_STEP, 2'b01);
        expect_out("diag_left_xmov", D_DIAG, S_XMOV, 2'b01);
        expect_out("diag_left_ymov", D_DIAG, S_YMOV, 2'b01);
        cyc();
        key_left = 2'b00;
        expect_out("sa_relleft_ymov", D_SA, S_YMOV, 2'b01);
        expect_out("sa_relleft_ydir", D_SA, S_YDIR, 2'b00);
        expect_out("sa_relleft_xmov", D_SA, S_XMOV, 2'b00);
        expect_out("sa_relleft_xdir", D_SA, S_XDIR, 2'b00);
        expect_out("sa_relleft_step", D_SA, S_STEP, 2'b01);
        cyc();
        key_up = 2'b00;
        expect_out("sa_relup_ymov", D_SA, S_YMOV, 2'b00);
        expect_out("sa_relup_step", D_SA, S_STEP, 2'b00);
        cyc();

        // Bomb cooldown on player 1: rises dropped while cooling down
        bomb_in  = 6'b100101;
        bomb_exp = 6'b100001;
        for (int i = 0; i < 6; i++) begin
            key_bomb = {bomb_in[i], 1'b0};
            expect_out("bomb_seq", D_DIAG, S_BOMB, {bomb_exp[i], 1'b0});
            cyc();
        end
        key_bomb = 2'b00;
        for (int i = 0; i < 4; i++) begin
            expect_out("bomb_cool", D_DIAG, S_BOMB, 2'b00);
            cyc();
        end
        key_bomb = 2'b10;
        expect_out("bomb_hold_first", D_DIAG, S_BOMB, 2'b10);
        cyc();
        for (int i = 0; i < 49; i++) begin
            expect_out("bomb_hold_norepeat", D_DIAG, S_BOMB, 2'b00);
            cyc();
        end
        key_bomb = 2'b00;
        for (int i = 0; i < 4; i++) cyc();

        // Enable gating with both players' keys held
        enable = 1'b0;
        key_right = 2'b01; key_down = 2'b10; key_bomb = 2'b10;
        for (int i = 0; i < 3; i++) begin
            expect_out("dis_step", D_DIAG, S_STEP, 2'b00);
            expect_out("dis_bomb", D_DIAG, S_BOMB, 2'b00);
            expect_out("dis_xmov", D_DIAG, S_XMOV, 2'b00);
            expect_out("dis_ymov", D_DIAG, S_YMOV, 2'b00);
            expect_out("dis_xdir_hold", D_DIAG, S_XDIR, 2'b00);
            expect_out("dis_ydir_hold", D_DIAG, S_YDIR, 2'b00);
            cyc();
        end
        enable = 1'b1;
        expect_out("en_step", D_DIAG, S_STEP, 2'b11);
        expect_out("en_bomb", D_DIAG, S_BOMB, 2'b00);
        expect_out("en_xmov", D_DIAG, S_XMOV, 2'b01);
        expect_out("en_ymov", D_DIAG, S_YMOV, 2'b10);
        expect_out("en_xdir", D_DIAG, S_XDIR, 2'b01);
        expect_out("en_ydir", D_DIAG, S_YDIR, 2'b10);
        cyc();
        key_right = 2'b00;
        expect_out("indep_xmov", D_DIAG, S_XMOV, 2'b00);
        expect_out("indep_ymov", D_DIAG, S_YMOV, 2'b10);
        expect_out("indep_step", D_DIAG, S_STEP, 2'b00);
        cyc();
        for (int i = 0; i < 2; i++) begin
            expect_out("indep_wait", D_DIAG, S_STEP, 2'b00);
            expect_out("indep_ymov_hold", D_DIAG, S_YMOV, 2'b10);
            cyc();
        end
        expect_out("indep_p1_repeat", D_DIAG, S_STEP, 2'b10);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
